music_mode_ctrl: RTL
====================

Name: music_mode_ctrl

Overview:
Top-level playback sequencer for the two-song music player. It turns debounced one-pulse button events and the note-ROM end-of-song flag into the 4-bit mode bus. That bus drives the elapsed-time counter, the note address generator and the audio output stage. It also produces an audio enable, the selected song index and a one-cycle address-clear strobe.

Parameters:
HOLD_TICKS, 3, number of tick pulses spent in ENDING before leaving it automatically (1..15).

Ports:
clk  input  1  system clock
rst  input  1  synchronous, active-high reset, sampled on rising edge of clk
tick  input  1  one-cycle enable pulse, nominally 1 Hz, used only by the ENDING hold counter
btn_sel  input  1  one-pulse song-select / stop button
btn_play  input  1  one-pulse play / resume button
btn_pause  input  1  one-pulse pause toggle
btn_mute  input  1  one-pulse mute toggle
song_end  input  1  one-cycle pulse: last note of the current song was reached
mode  output  4  registered mode code (encoding in Behaviour)
song_id  output  1  0 = song 1, 1 = song 2; registered
audio_en  output  1  1 only in PLAY1/PLAY2; registered
addr_clr  output  1  one-cycle pulse; note address generator restarts at 0

Behaviour:
- Mode encoding:
  - SEL1=0000, SEL2=0001, PLAY1=0010, PLAY2=0011, ENDING=0100
  - PLAY1_PS=0101, PLAY1_PM=0110, PLAY2_PS=0111, PLAY2_PM=1000
  - PS = paused; PM = muted. Both freeze the timer; audio is off in both.
- Reset: mode=SEL1, song_id=0, audio_en=0, addr_clr=0, hold counter=0. Reset mid-operation, including in ENDING, returns to SEL1 the next cycle.
- All outputs are registered and change on the clk edge following the input event, i.e. 1-cycle latency.
- Priority for simultaneous events (highest first): rst > song_end > btn_sel > btn_pause > btn_mute > btn_play. Exactly one transition per cycle; lower-priority events in the same cycle are dropped.
- Transitions (n = song_id):
  - SEL1: btn_sel -> SEL2 (song_id=1); btn_play -> PLAY1 with addr_clr=1.
  - SEL2: btn_sel -> SEL1 (song_id=0); btn_play -> PLAY2 with addr_clr=1.
  - PLAYn: song_end -> ENDING; btn_sel -> SELn (stop); btn_pause -> PLAYn_PS; btn_mute -> PLAYn_PM.
  - PLAYn_PS: btn_sel -> SELn; btn_pause or btn_play -> PLAYn; btn_mute -> PLAYn_PM. song_end is ignored.
  - PLAYn_PM: btn_sel -> SELn; btn_pause -> PLAYn_PS; btn_mute or btn_play -> PLAYn. song_end is ignored.
  - ENDING: btn_sel or btn_play -> SELn immediately. After HOLD_TICKS tick pulses -> SELn. The hold counter clears on ENDING entry and saturates.
- song_id changes only in SEL states.
- Illegal mode codes (1001..1111) -> SEL1 with song_id=0 on the next cycle.
- addr_clr is asserted for exactly one cycle, coincident with the first PLAYn cycle after SEL, and also on AUTO_REPLAY re-entry. It is never asserted on resume from PS/PM.

Optional Feature:
- Macro: MUSIC_AUTO_REPLAY_EN.
- When defined: ENDING hold expiry goes to PLAYn (same song_id) with addr_clr=1, instead of SELn. btn_sel/btn_play in ENDING still go to SELn.
- When undefined: behaviour is exactly as above.

Decomposition:
- Shared package music_pkg holds:
  - the nine mode code constants, also consumed by the timer and audio blocks;
  - the SONG1/SONG2 index constants.
- One natural sub-module, music_hold_cnt: a saturating tick counter with clear and a done flag, parameterised by HOLD_TICKS.

Test Plan:
- Reset then btn_sel, btn_sel, btn_sel, one cycle apart -> mode 0001, 0000, 0001; song_id 1, 0, 1; audio_en stays 0.
- In SEL2, btn_play -> mode=0011, audio_en=1, addr_clr=1 for exactly one cycle. Then btn_pause -> 0111 with audio_en=0; btn_play -> 0011 with no addr_clr.
- In PLAY1, song_end and btn_pause in the same cycle -> mode=0100. With HOLD_TICKS=3, three tick pulses -> 0000 on the cycle after the third tick. With MUSIC_AUTO_REPLAY_EN -> 0010 plus addr_clr.
- In PLAY1, btn_mute -> 0110. song_end while in 0110 -> no change. btn_pause -> 0101. btn_sel -> 0000.
- Reset asserted in ENDING after 2 ticks -> all outputs at reset values next cycle; a later ENDING entry still requires 3 fresh ticks.
- Illegal code forced into the mode register (1011) -> 0000 and song_id=0 on the next cycle.

Source files
------------

// File: rtl/music_pkg.sv
// Shared definitions for the music player: mode codes, song indices and
// small helpers that map a song index onto its per-song mode codes.
package music_pkg;

  localparam int unsigned MODE_W = 4;

  // Mode bus encoding, shared with the timer and audio output blocks.
  typedef enum logic [MODE_W-1:0] {
    MODE_SEL1     = 4'b0000,
    MODE_SEL2     = 4'b0001,
    MODE_PLAY1    = 4'b0010,
    MODE_PLAY2    = 4'b0011,
    MODE_ENDING   = 4'b0100,
    MODE_PLAY1_PS = 4'b0101,
    MODE_PLAY1_PM = 4'b0110,
    MODE_PLAY2_PS = 4'b0111,
    MODE_PLAY2_PM = 4'b1000
  } mode_t;

  localparam logic SONG1 = 1'b0;
  localparam logic SONG2 = 1'b1;

  function automatic mode_t sel_mode(input logic song);
    return (song == SONG2) ? MODE_SEL2 : MODE_SEL1;
  endfunction

  function automatic mode_t play_mode(input logic song);
    return (song == SONG2) ? MODE_PLAY2 : MODE_PLAY1;
  endfunction

  function automatic mode_t ps_mode(input logic song);
    return (song == SONG2) ? MODE_PLAY2_PS : MODE_PLAY1_PS;
  endfunction

  function automatic mode_t pm_mode(input logic song);
    return (song == SONG2) ? MODE_PLAY2_PM : MODE_PLAY1_PM;
  endfunction

endpackage

// File: rtl/music_hold_cnt.sv
// Saturating tick counter for the ENDING hold time.
// Ports:
//   clk, rst   - clock, synchronous active-high reset
//   clr        - synchronous clear (held while not in ENDING)
//   en         - count enable (a tick pulse while in ENDING)
//   done_c     - combinational: this enabled tick is the HOLD_TICKS-th one
module music_hold_cnt #(
  parameter int unsigned HOLD_TICKS = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic done_c
);

  localparam int unsigned CNT_W = 4;

  logic [CNT_W-1:0] cnt_q;

  // Count enabled ticks, stopping at HOLD_TICKS.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt_q <= '0;
    end else if (en && (cnt_q != CNT_W'(HOLD_TICKS))) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  // Fires on the tick that brings the count to HOLD_TICKS, so the mode
  // changes on the same edge the last tick is sampled.
  assign done_c = en && (cnt_q >= CNT_W'(HOLD_TICKS - 1));

endmodule

// File: rtl/music_mode_ctrl.sv
// Playback sequencer for the two-song music player. Converts one-pulse
// button events and the end-of-song flag into the registered mode bus.
// Optional build macro: MUSIC_AUTO_REPLAY_EN (ENDING hold expiry replays
// the current song instead of returning to its select state).
// Ports:
//   clk, rst                  - clock, synchronous active-high reset
//   tick                      - ~1 Hz enable pulse for the ENDING hold
//   btn_sel/play/pause/mute   - one-pulse button events
//   song_end                  - last note of the current song reached
//   mode                      - registered 4-bit mode code
//   song_id                   - selected song (0 = song 1, 1 = song 2)
//   audio_en                  - high only in PLAY1/PLAY2
//   addr_clr                  - one-cycle restart strobe for the note address
module music_mode_ctrl
  import music_pkg::*;
#(
  parameter int unsigned HOLD_TICKS = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tick,
  input  logic              btn_sel,
  input  logic              btn_play,
  input  logic              btn_pause,
  input  logic              btn_mute,
  input  logic              song_end,
  output logic [MODE_W-1:0] mode,
  output logic              song_id,
  output logic              audio_en,
  output logic              addr_clr
);

  mode_t state_q, state_d;
  logic  song_id_q, song_id_d;
  logic  audio_en_q;
  logic  addr_clr_q, addr_clr_d;
  logic  in_ending;
  logic  hold_done_c;

  assign in_ending = (state_q == MODE_ENDING);

  music_hold_cnt #(
    .HOLD_TICKS(HOLD_TICKS)
  ) u_hold_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (!in_ending),
    .en    (in_ending && tick),
    .done_c(hold_done_c)
  );

  // State and output registers; audio_en is decoded from the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= MODE_SEL1;
      song_id_q  <= SONG1;
      audio_en_q <= 1'b0;
      addr_clr_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      song_id_q  <= song_id_d;
      audio_en_q <= (state_d == MODE_PLAY1) || (state_d == MODE_PLAY2);
      addr_clr_q <= addr_clr_d;
    end
  end

  // Next-state logic; if/else order encodes event priority.
  always_comb begin
    state_d    = state_q;
    song_id_d  = song_id_q;
    addr_clr_d = 1'b0;
    case (state_q)
      MODE_SEL1: begin
        if (btn_sel) begin
          state_d   = MODE_SEL2;
          song_id_d = SONG2;
        end else if (btn_play) begin
          state_d    = MODE_PLAY1;
          addr_clr_d = 1'b1;
        end
      end
      MODE_SEL2: begin
        if (btn_sel) begin
          state_d   = MODE_SEL1;
          song_id_d = SONG1;
        end else if (btn_play) begin
          state_d    = MODE_PLAY2;
          addr_clr_d = 1'b1;
        end
      end
      MODE_PLAY1, MODE_PLAY2: begin
        if (song_end)       state_d = MODE_ENDING;
        else if (btn_sel)   state_d = sel_mode(song_id_q);
        else if (btn_pause) state_d = ps_mode(song_id_q);
        else if (btn_mute)  state_d = pm_mode(song_id_q);
      end
      MODE_PLAY1_PS, MODE_PLAY2_PS: begin
        if (btn_sel)                     state_d = sel_mode(song_id_q);
        else if (btn_pause)              state_d = play_mode(song_id_q);
        else if (btn_mute)               state_d = pm_mode(song_id_q);
        else if (btn_play)               state_d = play_mode(song_id_q);
      end
      MODE_PLAY1_PM, MODE_PLAY2_PM: begin
        if (btn_sel)                     state_d = sel_mode(song_id_q);
        else if (btn_pause)              state_d = ps_mode(song_id_q);
        else if (btn_mute || btn_play)   state_d = play_mode(song_id_q);
      end
      MODE_ENDING: begin
        if (btn_sel || btn_play) begin
          state_d = sel_mode(song_id_q);
        end else if (hold_done_c) begin
`ifdef MUSIC_AUTO_REPLAY_EN
          state_d    = play_mode(song_id_q);
          addr_clr_d = 1'b1;
`else
          state_d    = sel_mode(song_id_q);
`endif
        end
      end
      default: begin
        // Unused codes recover to a known idle state.
        state_d   = MODE_SEL1;
        song_id_d = SONG1;
      end
    endcase
  end

  assign mode     = state_q;
  assign song_id  = song_id_q;
  assign audio_en = audio_en_q;
  assign addr_clr = addr_clr_q;

endmodule
